// File: rtl/gate_alu_pipe.sv
// gate_alu_pipe: a single-stage pipelined bitwise ALU.
// A beat is accepted on a valid/ready handshake. Its result, together with the
// zero and all-ones flags, is registered one cycle later. A saturating counter
// tracks how many beats have been accepted.
module gate_alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_ones,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_y_zero;
  logic             r_y_ones;
  logic [CNT_W-1:0] r_count;

  logic             w_accept;
  logic [WIDTH-1:0] w_result;
  logic             w_zero;
  logic             w_ones;

  // The output register is free when it is empty, or when it is being drained this cycle.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Every result bit has its own 8-way gate mux.
  // Operand b is unused by NOT A (op 6) and PASS A (op 7).
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      // Select the gate function for this bit.
      always_comb begin
        w_result[gi] = 1'b0;
        case (op)
          3'd0: w_result[gi] =   a[gi] & b[gi];
          3'd1: w_result[gi] =   a[gi] | b[gi];
          3'd2: w_result[gi] =   a[gi] ^ b[gi];
          3'd3: w_result[gi] = ~(a[gi] & b[gi]);
          3'd4: w_result[gi] = ~(a[gi] | b[gi]);
          3'd5: w_result[gi] = ~(a[gi] ^ b[gi]);
          3'd6: w_result[gi] = ~a[gi];
          3'd7: w_result[gi] =   a[gi];
          default: w_result[gi] = 1'b0;
        endcase
      end
    end
  endgenerate

  // Flags come from the new result, so they always match the y they are registered with.
  assign w_zero = (w_result == '0);
  assign w_ones = &w_result;

  // Result register: load on accept. Otherwise hold y and the flags; valid
  // drops only when the held result is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_y_zero    <= 1'b1;
      r_y_ones    <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_y         <= w_result;
      r_y_zero    <= w_zero;
      r_y_ones    <= w_ones;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Accepted-beat counter, which saturates at its maximum instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_accept && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign y_zero    = r_y_zero;
  assign y_ones    = r_y_ones;
  assign op_count  = r_count;

endmodule

// File: doc/gate_alu_pipe.md
GATE_ALU_PIPE -- requirements
Module: gate_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal 1..64).
REQ-002 Parameter CNT_W, default 16, width of the accepted-operation counter (legal 2..32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  3  operation select, sampled with the beat.
REQ-010 out_valid  output  1  result register holds an unconsumed result.
REQ-011 out_ready  input  1  downstream accepts result this cycle.
REQ-012 y  output  WIDTH  registered bitwise result.
REQ-013 y_zero  output  1  registered flag, y == 0.
REQ-014 y_ones  output  1  registered flag, y is all ones.
REQ-015 op_count  output  CNT_W  number of accepted beats, saturating.

Function
REQ-016 Op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 PASS A; bitwise across all WIDTH bits; b ignored for ops 6 and 7.
REQ-017 Accept occurs in a cycle where in_valid && in_ready; a, b, op are sampled only on accept.
REQ-018 in_ready = !out_valid || out_ready (combinational; output register free or draining this cycle).
REQ-019 Latency: result of an accepted beat appears on y with out_valid = 1 on the cycle after accept (1 cycle).
REQ-020 Output consumed in a cycle where out_valid && out_ready.
REQ-021 Consume without accept in the same cycle: out_valid clears next cycle; y, y_zero, y_ones hold last value.
REQ-022 Simultaneous consume and accept: out_valid stays 1; y/flags update to the new result; no bubble, no loss.
REQ-023 out_valid && !out_ready: y, y_zero, y_ones, out_valid held stable; in_ready = 0; no beat accepted.
REQ-024 in_valid while in_ready = 0: no state change; upstream holds its beat.
REQ-025 y_zero and y_ones are computed from the new result and registered with y, never from a stale y.
REQ-026 For WIDTH = 1, y_zero = !y and y_ones = y.
REQ-027 op_count increments by 1 per accept; at 2^CNT_W - 1 it holds (saturates, no wrap).
REQ-028 Throughput: with out_ready held 1 and in_valid held 1, one beat accepted every cycle.
REQ-029 No combinational path from a, b, op to any output; in_ready depends only on out_valid and out_ready.

Reset
REQ-030 rst_n low asynchronously forces out_valid = 0, y = 0, y_zero = 1, y_ones = 0, op_count = 0, regardless of clk.
REQ-031 During reset, in_ready = 1 (follows REQ-018 with out_valid = 0); beats offered are not accepted until the first rising edge after rst_n deasserts.
REQ-032 Reset mid-operation discards any held result; the count restarts from 0.

Verification
REQ-033 WIDTH=8, out_ready=1; a=8'hF0, b=8'hCC, op=0..7 in back-to-back cycles -> y = C0, FC, 3C, 3F, 03, C3, 0F, F0 on consecutive cycles one cycle after each accept; out_valid = 1 throughout; op_count = 8.
REQ-034 Backpressure: accept a=8'hFF, b=8'hFF, op=0; hold out_ready=0 for 3 cycles while in_valid=1 with a=8'h00 -> y stays FF, y_ones=1, in_ready=0; on release, FF consumed and the 00 beat is accepted the same cycle; y=00, y_zero=1 next cycle.
REQ-035 Saturation: CNT_W=2, 5 accepted beats -> op_count = 0,1,2,3,3.
REQ-036 Reset mid-stream: out_valid=1, y=8'h5A; pull rst_n low between clock edges -> y=00, out_valid=0, y_zero=1, op_count=0 immediately, before the next edge.
REQ-037 WIDTH=1 exhaustive: all a, b, op combinations -> y matches the truth table; y_zero = !y; y_ones = y.
REQ-038 Idle: in_valid=0 for 5 cycles after a consume -> out_valid=0, y and op_count unchanged.
